// File: rtl/kbd_matrix_responder_if.sv
// Smart-keyboard link bundle: host-side serial pins plus the local matrix/host-word side.
// slave = keyboard responder, master = host or bench driving the link.
interface kbd_matrix_responder_if #(
  parameter int unsigned MATRIX_BITS = 72,
  parameter int unsigned HOST_BITS   = 16
);
  logic                   kio_clk_i;
  logic                   kio_host_data_i;
  logic                   kio_resp_data_o;
  logic [MATRIX_BITS-1:0] matrix_i;
  logic [HOST_BITS-1:0]   host_word_o;
  logic                   host_valid_o;
  logic                   frame_err_o;

  modport slave (
    input  kio_clk_i, kio_host_data_i, matrix_i,
    output kio_resp_data_o, host_word_o, host_valid_o, frame_err_o
  );

  modport master (
    output kio_clk_i, kio_host_data_i, matrix_i,
    input  kio_resp_data_o, host_word_o, host_valid_o, frame_err_o
  );
endinterface

// File: rtl/kbd_matrix_responder.sv
// Keyboard end of the smart-keyboard serial link: streams a key-matrix snapshot, captures the host word.
// Define KBD_RESP_PARITY_EN to append an odd-parity bit to every frame.
module kbd_matrix_responder #(
  parameter int unsigned MATRIX_BITS = 72,
  parameter int unsigned HOST_BITS   = 16,
  parameter int unsigned SYNC_GAP    = 64
) (
  input  logic                 bus_clk,
  input  logic                 bus_reset_n,
  kbd_matrix_responder_if.slave kio
);

`ifdef KBD_RESP_PARITY_EN
  localparam int unsigned FRAME_LEN = MATRIX_BITS + 1;
`else
  localparam int unsigned FRAME_LEN = MATRIX_BITS;
`endif
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned GAP_W = $clog2(SYNC_GAP + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [2:0]             kclk_sync_q;
  logic [1:0]             kdat_sync_q;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic [FRAME_LEN-1:0]   shift_q, shift_d;
  logic [HOST_BITS-1:0]   host_q, host_d;
  logic                   resp_q, resp_d;
  logic [HOST_BITS-1:0]   host_word_q, host_word_d;
  logic                   host_valid_q, host_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic                   kclk_s_c, kdat_s_c, rise_c, fall_c, gap_sat_c, take_rise_c;
  logic [CNT_W-1:0]       bitcnt_inc_c;
  logic [FRAME_LEN-1:0]   snap_c;

  // Bit [1] is the synchronised level; bit [2] is the delayed copy used for edge detection.
  assign kclk_s_c  = kclk_sync_q[1];
  assign kdat_s_c  = kdat_sync_q[1];
  assign rise_c    =  kclk_sync_q[1] & ~kclk_sync_q[2];
  assign fall_c    = ~kclk_sync_q[1] &  kclk_sync_q[2];
  assign gap_sat_c = (gap_q == GAP_W'(SYNC_GAP));
  assign bitcnt_inc_c = bitcnt_q + CNT_W'(1);

`ifdef KBD_RESP_PARITY_EN
  assign snap_c = {~^kio.matrix_i, kio.matrix_i};
`else
  assign snap_c = kio.matrix_i;
`endif

  // Low-time counter; saturation marks a frame boundary.
  always_comb begin
    gap_d = gap_q;
    if (kclk_s_c) begin
      gap_d = '0;
    end else if (!gap_sat_c) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    host_d       = host_q;
    resp_d       = resp_q;
    host_word_d  = host_word_q;
    host_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    take_rise_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        resp_d = 1'b1;
        if (gap_sat_c) begin
          shift_d  = snap_c;
          resp_d   = kio.matrix_i[0];
          bitcnt_d = '0;
          state_d  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (rise_c) begin
          state_d     = ST_SHIFT;
          take_rise_c = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise_c) begin
          take_rise_c = 1'b1;
        end else if (fall_c) begin
          shift_d = shift_q >> 1;
          resp_d  = shift_q[1];
        end else if (gap_sat_c && (bitcnt_q != '0)) begin
          // Aborted frame: the same gap serves as sync for the next one.
          frame_err_d = 1'b1;
          shift_d     = snap_c;
          resp_d      = kio.matrix_i[0];
          bitcnt_d    = '0;
          state_d     = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_rise_c) begin
      if (bitcnt_q < CNT_W'(HOST_BITS)) begin
        host_d = HOST_BITS'({kdat_s_c, host_q} >> 1);
      end
      bitcnt_d = bitcnt_inc_c;
      if (bitcnt_inc_c == CNT_W'(FRAME_LEN)) begin
        host_word_d  = host_d;
        host_valid_d = 1'b1;
        resp_d       = 1'b1;
        state_d      = ST_IDLE;
      end
    end
  end

  always_ff @(posedge bus_clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      state_q      <= ST_IDLE;
      kclk_sync_q  <= '0;
      kdat_sync_q  <= '0;
      gap_q        <= '0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      host_q       <= '0;
      resp_q       <= 1'b1;
      host_word_q  <= '0;
      host_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      kclk_sync_q  <= {kclk_sync_q[1:0], kio.kio_clk_i};
      kdat_sync_q  <= {kdat_sync_q[0], kio.kio_host_data_i};
      gap_q        <= gap_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      host_q       <= host_d;
      resp_q       <= resp_d;
      host_word_q  <= host_word_d;
      host_valid_q <= host_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign kio.kio_resp_data_o = resp_q;
  assign kio.host_word_o     = host_word_q;
  assign kio.host_valid_o    = host_valid_q;
  assign kio.frame_err_o     = frame_err_q;

endmodule
